argmax_stream: RTL
==================

// Module: argmax_stream
// PURPOSE
//  Parametrised final-decision unit for the classifier output layer. Consumes a stream of
//  NUM_CLASS scores, one per valid_in beat, and tracks the best and second-best scores on the fly.
//  Reports the winning class index, its score, and the top-1/top-2 margin one cycle after the last beat.
//  Accepts back-to-back frames with zero gap, and can abort and restart a frame on sof_in.
//  Sits between the last fully-connected layer and the result register/host interface.
// PARAMETERS
//  DATA_W     12  score width in bits (>=2)
//  NUM_CLASS  10  scores per frame (>=2)
//  SIGNED     1   1: two's-complement compare; 0: unsigned compare
//  localparam IDX_W = $clog2(NUM_CLASS)
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  rst_n      in   1          reset, synchronous, active-low
//  valid_in   in   1          data_in valid this cycle; there is no backpressure
//  sof_in     in   1          qualified by valid_in: this beat is class 0 of a new frame
//  data_in    in   DATA_W     score of the current class
//  busy       out  1          a frame is partially received (beat counter != 0)
//  valid_out  out  1          one-cycle pulse: result outputs valid
//  decision   out  IDX_W      index of the maximum score
//  max_val    out  DATA_W     maximum score
//  margin     out  DATA_W+1   max_val - second-best score, unsigned, never negative
//  frame_err  out  1          one-cycle pulse: partial frame discarded by sof_in
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge):
//    - all outputs 0;
//    - beat counter, best/second registers and indices cleared;
//    - any partial frame is discarded and produces no valid_out.
//  - Beat counter cnt (0..NUM_CLASS-1):
//    - increments on each accepted beat;
//    - wraps to 0 after beat NUM_CLASS-1;
//    - valid_in=0 gaps inside a frame are allowed; state is held during a gap.
//  - Beat with cnt==0 (or sof_in=1):
//    - best=data_in, best_idx=0;
//    - second=most negative representable value (SIGNED=1) or 0 (SIGNED=0).
//  - Beat k>0, compare using the SIGNED mode:
//    - if data_in > best: second<=best, best<=data_in, best_idx<=k;
//    - else if data_in > second: second<=data_in;
//    - compare is strict, so on ties the lowest index wins, and a tied score becomes second (margin 0).
//  - Latency:
//    - on the clk edge that accepts beat NUM_CLASS-1, decision/max_val/margin are registered from the final compare;
//    - valid_out=1 for exactly the next cycle;
//    - outputs hold their value until the next result or reset;
//    - valid_out is 0 in all other cycles.
//  - Back-to-back frames:
//    - a beat in the cycle where valid_out=1 is class 0 of the next frame;
//    - no bubble is required, so sustained throughput is 1 frame per NUM_CLASS cycles.
//  - sof_in=1 with valid_in=1:
//    - beat is treated as class 0 and cnt<=1;
//    - if cnt!=0 before the beat: frame_err pulses for 1 cycle, the partial frame is dropped, no valid_out;
//    - if cnt==0: sof_in is redundant, no error.
//    - sof_in with valid_in=0 is ignored.
//  - margin:
//    - computed in DATA_W+1 bits (sign/zero-extend both operands, subtract);
//    - full range, no saturation needed.
//  - busy = (cnt != 0), registered.
// TESTING
//  - S1 DATA_W=12, SIGNED=1, scores 5,-3,120,7,0,119,-2048,2047,1,3 -> valid_out one cycle after beat 9; decision=7, max_val=2047, margin=1927
//  - S2 scores 10,40,40,2,40,0,0,0,0,0 -> decision=1, max_val=40, margin=0
//  - S3 all ten scores -2048 (SIGNED=1) -> decision=0, margin=0; same pattern 12'h800 with SIGNED=0 -> decision=0, max_val=2048
//  - S4 three frames back-to-back with no gaps, winners at 9, 0, 4 -> exactly 3 valid_out pulses, 10 cycles apart, decisions 9,0,4
//  - S5 4 beats, then sof_in with a full 10-beat frame (max at idx 6) -> frame_err pulse on the sof cycle+1; single valid_out, decision=6
//  - S6 reset asserted after beat 5, then full frame max at idx 2 -> outputs 0 during reset; one valid_out, decision=2; random gaps in valid_in give the same results

Source files
------------

// File: rtl/argmax_stream.sv
// -----------------------------------------------------------------------------
// argmax_stream
//   Final-decision unit for the classifier output layer. Scores arrive one per
//   valid_in beat, class 0 first. The running best and second-best scores are
//   tracked on the fly, so the winning class, its score and the top-1/top-2
//   margin are registered on the edge that accepts the last beat and presented
//   with a one-cycle valid_out pulse. Frames may follow each other with no gap,
//   idle cycles inside a frame are allowed, and sof_in restarts a frame,
//   discarding any partial one.
//
// Parameters
//   DATA_W     score width in bits (>=2)
//   NUM_CLASS  scores per frame (>=2)
//   SIGNED     1: two's-complement compare, 0: unsigned compare
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous, active-low reset
//   valid_in   data_in carries a score this cycle (no backpressure)
//   sof_in     with valid_in: this beat is class 0 of a new frame
//   data_in    score of the current class
//   busy       a frame is partially received
//   valid_out  one-cycle pulse, result outputs valid
//   decision   index of the maximum score (lowest index on ties)
//   max_val    maximum score
//   margin     max_val minus second-best score, unsigned
//   frame_err  one-cycle pulse, partial frame discarded by sof_in
// -----------------------------------------------------------------------------
module argmax_stream #(
  parameter  int DATA_W    = 12,
  parameter  int NUM_CLASS = 10,
  parameter  int SIGNED    = 1,
  localparam int IDX_W     = $clog2(NUM_CLASS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              valid_out,
  output logic [IDX_W-1:0]  decision,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W:0]   margin,
  output logic              frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  // Seed for the second-best register: the smallest representable score, so
  // that any real score of the frame displaces it.
  localparam logic [DATA_W-1:0] SECOND_SEED =
    (SIGNED != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  // Strict greater-than in the configured number format.
  function automatic logic score_gt(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    a_s = signed'(a);
    b_s = signed'(b);
    if (SIGNED != 0) score_gt = (a_s > b_s);
    else             score_gt = (a > b);
  endfunction

  // Widen a score by one bit in the configured number format.
  function automatic logic signed [DATA_W:0] score_ext(input logic [DATA_W-1:0] a);
    if (SIGNED != 0) score_ext = signed'({a[DATA_W-1], a});
    else             score_ext = signed'({1'b0, a});
  endfunction

  // best >= second always holds, so the one-bit-wider difference is exact and
  // non-negative; no saturation is required.
  function automatic logic [DATA_W:0] score_margin(input logic [DATA_W-1:0] best,
                                                   input logic [DATA_W-1:0] second);
    logic signed [DATA_W:0] diff;
    diff = score_ext(best) - score_ext(second);
    score_margin = unsigned'(diff);
  endfunction

  // Running frame state
  logic [IDX_W-1:0]  cnt_p0;
  logic [DATA_W-1:0] best_p0;
  logic [DATA_W-1:0] second_p0;
  logic [IDX_W-1:0]  best_idx_p0;

  // Combinational update of the running state for the current beat
  logic              first_beat;
  logic              last_beat;
  logic              abort_beat;
  logic [IDX_W-1:0]  beat_idx;
  logic [IDX_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] best_nxt;
  logic [DATA_W-1:0] second_nxt;
  logic [IDX_W-1:0]  best_idx_nxt;

  // Result registers
  logic              vld_p1;
  logic [IDX_W-1:0]  decision_p1;
  logic [DATA_W-1:0] max_val_p1;
  logic [DATA_W:0]   margin_p1;
  logic              frame_err_p1;
  logic              busy_p1;

  always_comb begin
    first_beat = sof_in || (cnt_p0 == '0);
    beat_idx   = sof_in ? '0 : cnt_p0;
    // sof_in forces class 0, so it can never be the last beat (NUM_CLASS >= 2).
    last_beat  = valid_in && (beat_idx == LAST_IDX);
    abort_beat = valid_in && sof_in && (cnt_p0 != '0);

    cnt_nxt = cnt_p0;
    if (valid_in) begin
      if (last_beat) cnt_nxt = '0;
      else           cnt_nxt = beat_idx + IDX_W'(1);
    end

    best_nxt     = best_p0;
    second_nxt   = second_p0;
    best_idx_nxt = best_idx_p0;
    if (first_beat) begin
      best_nxt     = data_in;
      second_nxt   = SECOND_SEED;
      best_idx_nxt = '0;
    end else if (score_gt(data_in, best_p0)) begin
      best_nxt     = data_in;
      second_nxt   = best_p0;
      best_idx_nxt = beat_idx;
    end else if (score_gt(data_in, second_p0)) begin
      // A score tied with the best lands here and yields a zero margin.
      second_nxt   = data_in;
    end
  end

  // ---- stage p0: running best/second state ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0      <= '0;
      best_p0     <= '0;
      second_p0   <= '0;
      best_idx_p0 <= '0;
    end else if (valid_in) begin
      cnt_p0      <= cnt_nxt;
      best_p0     <= best_nxt;
      second_p0   <= second_nxt;
      best_idx_p0 <= best_idx_nxt;
    end
  end

  // ---- stage p1: registered result and status ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      decision_p1  <= '0;
      max_val_p1   <= '0;
      margin_p1    <= '0;
      frame_err_p1 <= 1'b0;
      busy_p1      <= 1'b0;
    end else begin
      vld_p1       <= last_beat;
      frame_err_p1 <= abort_beat;
      busy_p1      <= (cnt_nxt != '0);
      if (last_beat) begin
        decision_p1 <= best_idx_nxt;
        max_val_p1  <= best_nxt;
        margin_p1   <= score_margin(best_nxt, second_nxt);
      end
    end
  end

  assign valid_out = vld_p1;
  assign decision  = decision_p1;
  assign max_val   = max_val_p1;
  assign margin    = margin_p1;
  assign frame_err = frame_err_p1;
  assign busy      = busy_p1;

endmodule
